// File: rtl/register_file_if.sv
// AXI-stream style valid/ready channel carrying a W-bit payload.
// Latency: none, this is wiring only.
// Backpressure: the master holds tdata/tvalid until the slave returns tready.
interface axis_if #(
    parameter int W = 32
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport m (output tdata, output tvalid, input tready);
    modport s (input tdata, input tvalid, output tready);
endinterface

// File: rtl/register_file.sv
// Integer register file with decode->execute skid stage and write-back bypass.
// Latency: 1 cycle from idrf accept to rfex tvalid, full 1 instr/cycle throughput.
// Backpressure: idrf tready = !out_vld || rfex tready; the held entry snoops write-backs.
// Optional: OFFNARISCV_RF_RESET_CLEAR_EN clears x1..x31 on rst; otherwise the array has no reset.
module register_file #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int CMD_W    = 8
) (
    input  logic clk,
    input  logic rst,
    axis_if.s    idrf_axis_if,
    axis_if.m    rfex_axis_if,
    axis_if.s    wb_axis_if,
    input  logic invalidate
);

    typedef struct packed {
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN-1:0]   imm;
        logic [CMD_W-1:0]  cmd;
        logic              fwd_rs1;
        logic              fwd_rs2;
        logic [2*XLEN-1:0] if_data;
    } idrf_tdata_t;

    typedef struct packed {
        idrf_tdata_t     id;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
    } rfex_tdata_t;

    // x0 has no storage; only x1..x(NUM_REGS-1) exist.
    logic [XLEN-1:0] regs [1:NUM_REGS-1];

    idrf_tdata_t     in_beat;
    rfex_tdata_t     out_data;
    logic            out_vld;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_we;
    logic            accept;
    logic            out_hs;
    logic [XLEN-1:0] rs1_rd;
    logic [XLEN-1:0] rs2_rd;

    function automatic logic in_range(input logic [4:0] idx);
        return int'(idx) < NUM_REGS;
    endfunction

    assign in_beat = idrf_axis_if.tdata;
    assign wb_rd   = wb_axis_if.tdata[XLEN+4:XLEN];
    assign wb_data = wb_axis_if.tdata[XLEN-1:0];

    // Write-backs to x0 or beyond the array are dropped, as is anything in the reset cycle.
    assign wb_we = wb_axis_if.tvalid && (wb_rd != 5'd0) && in_range(wb_rd) && !rst;

    assign wb_axis_if.tready = 1'b1;

    // rst forces the reset-visible values directly so they hold during the reset cycle too.
    assign idrf_axis_if.tready = rst || !out_vld || rfex_axis_if.tready;
    assign rfex_axis_if.tvalid = out_vld && !rst;
    assign rfex_axis_if.tdata  = rst ? '0 : out_data;

    assign accept = idrf_axis_if.tvalid && idrf_axis_if.tready;
    assign out_hs = out_vld && rfex_axis_if.tready;

    // Source operand read with same-cycle write-back bypass; x0 always reads zero.
    always_comb begin
        rs1_rd = '0;
        rs2_rd = '0;
        if (in_beat.rs1 != 5'd0 && in_range(in_beat.rs1)) begin
            if (wb_axis_if.tvalid && wb_rd == in_beat.rs1) begin
                rs1_rd = wb_data;
            end else begin
                rs1_rd = regs[in_beat.rs1];
            end
        end
        if (in_beat.rs2 != 5'd0 && in_range(in_beat.rs2)) begin
            if (wb_axis_if.tvalid && wb_rd == in_beat.rs2) begin
                rs2_rd = wb_data;
            end else begin
                rs2_rd = regs[in_beat.rs2];
            end
        end
    end

`ifdef OFFNARISCV_RF_RESET_CLEAR_EN
    // Register array write port, cleared by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[wb_rd] <= wb_data;
        end
    end
`else
    // Register array write port, no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wb_we) begin
            regs[wb_rd] <= wb_data;
        end
    end
`endif

    // Output entry: load on accept, otherwise keep operands fresh while stalled downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else begin
            if (invalidate) begin
                out_vld <= 1'b0;
            end else if (accept) begin
                out_vld <= 1'b1;
            end else if (out_hs) begin
                out_vld <= 1'b0;
            end

            if (accept) begin
                out_data.id       <= in_beat;
                out_data.rs1_data <= rs1_rd;
                out_data.rs2_data <= rs2_rd;
            end else if (out_vld && !rfex_axis_if.tready) begin
                if (wb_we && wb_rd == out_data.id.rs1) begin
                    out_data.rs1_data <= wb_data;
                end
                if (wb_we && wb_rd == out_data.id.rs2) begin
                    out_data.rs2_data <= wb_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: directed vector table, multi-cycle corner sequences, random run.
// Latency: checks outputs 2 time units after each rising edge, after inputs settle.
// Backpressure: rfex tready is driven both directed and randomly.
module tb_register_file;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [7:0]  cmd;
        logic        fwd_rs1;
        logic        fwd_rs2;
        logic [63:0] if_data;
    } idrf_t;

    typedef struct packed {
        idrf_t       id;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
    } rfex_t;

    typedef struct {
        logic [4:0]  pre_rd;
        logic [31:0] pre_dat;
        logic        same_vld;
        logic [4:0]  same_rd;
        logic [31:0] same_dat;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic invalidate = 1'b0;

    axis_if #(.W($bits(idrf_t))) idrf_if ();
    axis_if #(.W($bits(rfex_t))) rfex_if ();
    axis_if #(.W(37))            wb_if ();

    register_file #(.XLEN(32), .NUM_REGS(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .idrf_axis_if (idrf_if),
        .rfex_axis_if (rfex_if),
        .wb_axis_if   (wb_if),
        .invalidate   (invalidate)
    );

    always #5 clk = ~clk;

    rfex_t rout;
    assign rout = rfex_if.tdata;

    int checks = 0;
    int failures = 0;

    logic [31:0] mregs [32];
    idrf_t       expq [$];
    vec_t        vecs [6];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        idrf_if.tvalid = 1'b0;
        wb_if.tvalid   = 1'b0;
        invalidate     = 1'b0;
    endtask

    function automatic idrf_t make_beat(input logic [4:0] rs1, input logic [4:0] rs2, input logic [7:0] tag);
        idrf_t b;
        b.rs1     = rs1;
        b.rs2     = rs2;
        b.rd      = tag[4:0];
        b.imm     = {tag, 8'h3C, ~tag, 8'hA1};
        b.cmd     = tag ^ 8'h5A;
        b.fwd_rs1 = tag[0];
        b.fwd_rs2 = tag[1];
        b.if_data = {24'h0, tag, 24'hFFFFFF, ~tag};
        return b;
    endfunction

    task automatic issue(input idrf_t b);
        idrf_if.tdata  = b;
        idrf_if.tvalid = 1'b1;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        wb_if.tdata  = {rd, d};
        wb_if.tvalid = 1'b1;
    endtask

    initial begin
        idrf_t b;
        logic  rdy;
        logic  exp_vld;
        logic  exp_rdy;
        logic  in_v;
        logic  wb_v;
        logic  inv;
        logic [4:0]  wrd;
        logic [31:0] wdat;

        idrf_if.tdata  = '0;
        wb_if.tdata    = '0;
        rfex_if.tready = 1'b1;
        idle();

        vecs[0] = '{5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{5'd0,  32'h0,        1'b1, 5'd7,  32'h12345678, 5'd7,  5'd5,  32'h12345678, 32'hDEADBEEF};
        vecs[2] = '{5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[3] = '{5'd31, 32'hCAFEF00D, 1'b1, 5'd31, 32'h11111111, 5'd31, 5'd31, 32'h11111111, 32'h11111111};
        vecs[4] = '{5'd1,  32'h00000001, 1'b1, 5'd2,  32'h00000002, 5'd1,  5'd2,  32'h00000001, 32'h00000002};
        vecs[5] = '{5'd7,  32'h0000AAAA, 1'b0, 5'd0,  32'h0,        5'd5,  5'd7,  32'hDEADBEEF, 32'h0000AAAA};

        // Reset state, checked during and after rst.
        step();
        #1;
        check("rst_during_vld", rfex_if.tvalid, 1'b0);
        check("rst_during_rdy", idrf_if.tready, 1'b1);
        check("rst_during_dat", rfex_if.tdata, '0);
        rst = 1'b0;
        step();
        #1;
        check("rst_after_vld", rfex_if.tvalid, 1'b0);
        check("rst_after_rdy", idrf_if.tready, 1'b1);

        // Table: write, then issue (optionally with a same-cycle write), check one cycle later.
        for (int i = 0; i < 6; i++) begin
            idle();
            wb(vecs[i].pre_rd, vecs[i].pre_dat);
            step();
            idle();
            b = make_beat(vecs[i].rs1, vecs[i].rs2, 8'(i + 1));
            issue(b);
            if (vecs[i].same_vld) wb(vecs[i].same_rd, vecs[i].same_dat);
            #1;
            check("tbl_in_rdy", idrf_if.tready, 1'b1);
            step();
            idle();
            #1;
            check("tbl_vld", rfex_if.tvalid, 1'b1);
            check("tbl_payload", rout.id, b);
            check("tbl_rs1", rout.rs1_data, vecs[i].exp1);
            check("tbl_rs2", rout.rs2_data, vecs[i].exp2);
            step();
        end

        // Stall downstream; a write to the held rs2 must reach the held entry.
        rfex_if.tready = 1'b0;
        b = make_beat(5'd5, 5'd3, 8'd40);
        issue(b);
        step();
        idle();
        #1;
        check("hold_vld", rfex_if.tvalid, 1'b1);
        check("hold_in_rdy", idrf_if.tready, 1'b0);
        wb(5'd3, 32'hA5A5A5A5);
        step();
        idle();
        #1;
        check("hold_rs2_upd", rout.rs2_data, 32'hA5A5A5A5);
        check("hold_rs1_keep", rout.rs1_data, 32'hDEADBEEF);
        check("hold_in_rdy2", idrf_if.tready, 1'b0);
        rfex_if.tready = 1'b1;
        #1;
        check("rel_in_rdy", idrf_if.tready, 1'b1);
        check("rel_payload", rout.id, b);
        check("rel_rs2", rout.rs2_data, 32'hA5A5A5A5);
        step();
        #1;
        check("rel_empty", rfex_if.tvalid, 1'b0);

        // Back-to-back stream of 4 beats, one output per cycle in order.
        for (int i = 0; i < 4; i++) begin
            issue(make_beat(5'd0, 5'd0, 8'(50 + i)));
            #1;
            if (i > 0) begin
                check("strm_vld", rfex_if.tvalid, 1'b1);
                check("strm_order", rout.id.if_data, make_beat(5'd0, 5'd0, 8'(49 + i)).if_data);
            end
            step();
        end
        idle();
        #1;
        check("strm_last", rout.id.if_data, make_beat(5'd0, 5'd0, 8'd53).if_data);
        step();
        #1;
        check("strm_drain", rfex_if.tvalid, 1'b0);

        // Invalidate alongside an accept; the write-back in that cycle must still land.
        issue(make_beat(5'd0, 5'd0, 8'd60));
        step();
        issue(make_beat(5'd0, 5'd0, 8'd61));
        invalidate = 1'b1;
        wb(5'd9, 32'h00000099);
        #1;
        check("inv_prev_out", rout.id.if_data, make_beat(5'd0, 5'd0, 8'd60).if_data);
        check("inv_in_rdy", idrf_if.tready, 1'b1);
        step();
        idle();
        #1;
        check("inv_drop", rfex_if.tvalid, 1'b0);
        rfex_if.tready = 1'b0;
        issue(make_beat(5'd0, 5'd0, 8'd62));
        step();
        idle();
        #1;
        check("inv_held_vld", rfex_if.tvalid, 1'b1);
        invalidate = 1'b1;
        step();
        invalidate = 1'b0;
        #1;
        check("inv_held_drop", rfex_if.tvalid, 1'b0);
        rfex_if.tready = 1'b1;
        issue(make_beat(5'd9, 5'd0, 8'd63));
        step();
        idle();
        #1;
        check("inv_wb_kept", rout.rs1_data, 32'h00000099);
        step();

        // Reset mid-operation with a pending write-back and a held entry.
        wb(5'd9, 32'h00000055);
        step();
        idle();
        rfex_if.tready = 1'b0;
        issue(make_beat(5'd9, 5'd0, 8'd70));
        step();
        idle();
        rst = 1'b1;
        wb(5'd10, 32'h00000099);
        #1;
        check("rst2_during_vld", rfex_if.tvalid, 1'b0);
        check("rst2_during_rdy", idrf_if.tready, 1'b1);
        step();
        rst = 1'b0;
        idle();
        rfex_if.tready = 1'b1;
        #1;
        check("rst2_after_vld", rfex_if.tvalid, 1'b0);
        check("rst2_after_dat", rfex_if.tdata, '0);
`ifdef OFFNARISCV_RF_RESET_CLEAR_EN
        issue(make_beat(5'd9, 5'd10, 8'd71));
        step();
        idle();
        #1;
        check("rst_clear_x9", rout.rs1_data, 32'h0);
        check("rst_clear_x10", rout.rs2_data, 32'h0);
        step();
`endif

        // Random run against the architectural model: delivered operands equal the
        // register value as it stood before the delivery cycle's own write-back.
        mregs[0] = '0;
        for (int r = 1; r < 32; r++) begin
            mregs[r] = $urandom;
            wb(5'(r), mregs[r]);
            step();
        end
        idle();
        step();
        for (int c = 0; c < 3000; c++) begin
            in_v = ($urandom_range(0, 3) != 0);
            b.rs1     = 5'($urandom_range(0, 31));
            b.rs2     = 5'($urandom_range(0, 31));
            b.rd      = 5'($urandom);
            b.imm     = $urandom;
            b.cmd     = 8'($urandom);
            b.fwd_rs1 = 1'($urandom);
            b.fwd_rs2 = 1'($urandom);
            b.if_data = {$urandom, $urandom};
            rdy  = ($urandom_range(0, 3) != 0);
            wb_v = 1'($urandom);
            wrd  = 5'($urandom_range(0, 31));
            if (expq.size() != 0 && $urandom_range(0, 2) == 0) wrd = expq[0].rs2;
            else if ($urandom_range(0, 3) == 0) wrd = b.rs1;
            wdat = $urandom;
            inv  = ($urandom_range(0, 31) == 0);

            idrf_if.tdata  = b;
            idrf_if.tvalid = in_v;
            rfex_if.tready = rdy;
            wb_if.tdata    = {wrd, wdat};
            wb_if.tvalid   = wb_v;
            invalidate     = inv;
            #1;
            exp_vld = (expq.size() != 0);
            exp_rdy = !exp_vld || rdy;
            check("rnd_vld", rfex_if.tvalid, exp_vld);
            check("rnd_in_rdy", idrf_if.tready, exp_rdy);
            if (exp_vld && rdy) begin
                check("rnd_payload", rout.id, expq[0]);
                check("rnd_rs1", rout.rs1_data, mregs[expq[0].rs1]);
                check("rnd_rs2", rout.rs2_data, mregs[expq[0].rs2]);
                void'(expq.pop_front());
            end
            if (inv) expq.delete();
            else if (in_v && exp_rdy) expq.push_back(b);
            if (wb_v && wrd != 5'd0) mregs[wrd] = wdat;
            step();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter XLEN, default 32; register and operand data width.
REQ-002 Parameter NUM_REGS, default 32; architectural register count; x0 is hardwired to zero.
REQ-003 Port clk, input, 1; sole clock, all state on rising edge.
REQ-004 Port rst, input, 1; synchronous, active-high reset.
REQ-005 Port idrf_axis_if, axis_if.s, $bits(idrf_tdata_t); decoded instruction from decoder (rs1, rs2, rd, immediate, commands, fwd flags, if_data).
REQ-006 Port rfex_axis_if, axis_if.m, $bits(rfex_tdata_t); idrf_tdata_t payload plus rs1_data and rs2_data (XLEN each) to execute.
REQ-007 Port wb_axis_if, axis_if.s, 5+XLEN; write-back {rd[4:0], data[XLEN-1:0]}; tready tied 1.
REQ-008 Port invalidate, input, 1; pipeline flush.

Function
REQ-009 Storage SHALL be NUM_REGS-1 XLEN-bit registers (x1..x31); reads of x0 SHALL return 0; writes to x0 SHALL be discarded.
REQ-010 A write SHALL occur on any cycle with wb tvalid=1 and rd!=0; the value is visible to array reads the following cycle.
REQ-011 Output stage SHALL be one registered entry (out_vld, out_data); latency is 1 cycle from idrf accept to rfex tvalid.
REQ-012 idrf tready SHALL be !out_vld || rfex tready (no combinational path from rfex tready beyond this term); a beat is accepted when tvalid && tready.
REQ-013 On accept, rsN_data SHALL be: 0 if rsN==0; else wb data if wb tvalid && wb rd==rsN (same-cycle bypass); else array[rsN].
REQ-014 While out_vld && !rfex tready, out_data SHALL hold stable except: if wb tvalid && wb rd!=0 && wb rd==held rsN, held rsN_data SHALL update to wb data next cycle (rs1 and rs2 independently).
REQ-015 All idrf payload fields (including fwd_rs1/fwd_rs2, immediate, commands, if_data) SHALL pass through unmodified.
REQ-016 out_vld next = 0 if invalidate; else 1 on accept; else 0 on rfex handshake without accept; else hold.
REQ-017 Invalidate SHALL drop the output entry and any beat accepted in the same cycle; tready behaviour per REQ-012 is unchanged during invalidate.
REQ-018 Invalidate SHALL NOT block or cancel a write-back in the same cycle.
REQ-019 Simultaneous rfex handshake and idrf accept SHALL replace the entry with no bubble (full throughput, 1 instr/cycle).

Reset
REQ-020 During and after rst: rfex tvalid=0, out_data=0, idrf tready=1.
REQ-021 rst mid-transfer SHALL discard the held entry; write-backs in the reset cycle are ignored.
REQ-022 Register array reset behaviour per REQ-023/REQ-024.

Configuration
REQ-023 With OFFNARISCV_RF_RESET_CLEAR_EN defined, rst SHALL clear x1..x31 to 0 in the reset cycle.
REQ-024 Without OFFNARISCV_RF_RESET_CLEAR_EN, the array SHALL have no reset (RAM-inferable); contents after reset are undefined until written, and the output stage still resets per REQ-020.

Verification
REQ-025 Write wb rd=5 data=0xDEADBEEF; next cycle issue rs1=5 rs2=0 -> rfex rs1_data=0xDEADBEEF, rs2_data=0 one cycle later.
REQ-026 Same cycle: wb rd=7 data=0x12345678 and issue rs1=7 -> rs1_data=0x12345678 (bypass).
REQ-027 wb rd=0 data=0xFFFFFFFF then read rs1=0 -> rs1_data=0.
REQ-028 Hold rfex tready=0 with entry rs2=3 out; wb rd=3 data=0xA5A5A5A5; release tready -> delivered rs2_data=0xA5A5A5A5; idrf tready=0 while held.
REQ-029 Stream 4 beats with rfex tready=1 -> 4 outputs on consecutive cycles in order; assert invalidate on cycle 2 with accept -> that beat and held beat never appear, rfex tvalid=0 next cycle.
REQ-030 With OFFNARISCV_RF_RESET_CLEAR_EN: write x9=0x55, pulse rst, read rs1=9 -> 0; without macro: rfex tvalid=0 after rst, array value not checked.
